// File: rtl/ac_write_arbiter.sv
// Write sequencer for the accumulator: grants one of clear / memory-load / ALU-result per
// write cycle, drives the matching one-hot strobe, then returns a one-cycle ack.
module ac_write_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_mem,
  input  logic             req_alu,
  input  logic             req_clr,
  output logic             ac_write_en,
  output logic             ac_alu_write_en,
  output logic             ac_reset,
  output logic             ack_mem,
  output logic             ack_alu,
  output logic             ack_clr,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: req_* is a level held by the requester until its ack_* pulse. A request is
  // granted at an IDLE/ACK edge, strobed for one cycle, and acked in the cycle after that.
  // A requester whose ack is high this cycle is not eligible, so a held req re-arbitrates.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_rr_q, last_rr_d;  // 1 = last mem/alu grant went to alu
  logic               wr_q, wr_d;
  logic               alu_q, alu_d;
  logic               clr_q, clr_d;
  logic               ack_mem_q, ack_mem_d;
  logic               ack_alu_q, ack_alu_d;
  logic               ack_clr_q, ack_clr_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic elig_mem, elig_alu, elig_clr;
  logic g_mem, g_alu, g_clr;
  logic any_elig, multi_elig;

  assign elig_mem = req_mem & ~ack_mem_q;
  assign elig_alu = req_alu & ~ack_alu_q;
  assign elig_clr = req_clr & ~ack_clr_q;

  // Clear has absolute priority; a mem/alu tie goes to whichever did not win last time.
  assign g_clr = elig_clr;
  assign g_mem = ~elig_clr & elig_mem & (~elig_alu | last_rr_q);
  assign g_alu = ~elig_clr & elig_alu & (~elig_mem | ~last_rr_q);

  assign any_elig   = elig_mem | elig_alu | elig_clr;
  assign multi_elig = (elig_mem & elig_alu) | (elig_clr & (elig_mem | elig_alu));

  always_comb begin
    state_d   = state_q;
    last_rr_d = last_rr_q;
    wr_d      = 1'b0;
    alu_d     = 1'b0;
    clr_d     = 1'b0;
    ack_mem_d = 1'b0;
    ack_alu_d = 1'b0;
    ack_clr_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, ACK: begin
        if (any_elig) begin
          state_d = STROBE;
          wr_d    = g_mem;
          alu_d   = g_alu;
          clr_d   = g_clr;
          if (g_mem) last_rr_d = 1'b0;
          if (g_alu) last_rr_d = 1'b1;
          if (multi_elig && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        // The write is committed by the strobe, so the ack follows even if req dropped.
        state_d   = ACK;
        ack_mem_d = wr_q;
        ack_alu_d = alu_q;
        ack_clr_d = clr_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_rr_q <= 1'b1;
      wr_q      <= 1'b0;
      alu_q     <= 1'b0;
      clr_q     <= 1'b0;
      ack_mem_q <= 1'b0;
      ack_alu_q <= 1'b0;
      ack_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_rr_q <= last_rr_d;
      wr_q      <= wr_d;
      alu_q     <= alu_d;
      clr_q     <= clr_d;
      ack_mem_q <= ack_mem_d;
      ack_alu_q <= ack_alu_d;
      ack_clr_q <= ack_clr_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ac_write_en     = wr_q;
  assign ac_alu_write_en = alu_q;
  assign ac_reset        = clr_q;
  assign ack_mem         = ack_mem_q;
  assign ack_alu         = ack_alu_q;
  assign ack_clr         = ack_clr_q;
  assign busy            = busy_q;
  assign conflict_cnt    = cnt_q;
  assign state_dbg       = state_q;

endmodule
